// File: rtl/game_countdown_timer.sv
// Round countdown timer: turns rising edges of the 1 Hz sec_in wave into clk ticks and
// counts a BCD round length down to 00, with pause, restart, warning and end-of-round pulse.
module game_countdown_timer #(
    parameter int unsigned START_SECONDS = 60,
    parameter int unsigned WARN_SECONDS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_in,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       warn,
    output logic       time_up
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] START_TENS = 4'(START_SECONDS / 10);
    localparam logic [3:0] START_ONES = 4'(START_SECONDS % 10);
    localparam logic [6:0] WARN_LIMIT = 7'(WARN_SECONDS);

    logic       s1_q, s2_q, s3_q;
    logic       tick;
    logic [1:0] state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       running_q;
    logic       time_up_q, time_up_d;
    logic [6:0] remaining;

    // s1/s2 resynchronise the asynchronous wave; s3 is only for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sec_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tick = s2_q & ~s3_q;

    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        time_up_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    tens_d  = START_TENS;
                    ones_d  = START_ONES;
                end
            end
            ST_RUN: begin
                // Pause wins over a coincident tick; that tick is lost.
                if (pause) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    if (tens_q == 4'd0 && ones_q == 4'd1) begin
                        ones_d    = 4'd0;
                        state_d   = ST_DONE;
                        time_up_d = 1'b1;
                    end else if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end
                end
            end
            ST_PAUSE: begin
                if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tens_q    <= START_TENS;
            ones_q    <= START_ONES;
            running_q <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            running_q <= (state_d == ST_RUN);
            time_up_q <= time_up_d;
        end
    end

    assign remaining = 7'(tens_q) * 7'd10 + 7'(ones_q);

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign running = running_q;
    assign time_up = time_up_q;
    assign warn    = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && (remaining <= WARN_LIMIT);

endmodule
